// File: rtl/pulse_divider_if.sv
// Control/status bundle for one pulse_divider stage.
// The master drives the strobes and divisor; the slave returns pulse and status.
interface pulse_divider_if #(
  parameter int WIDTH = 8
);
  logic             pulseIn;
  logic             start;
  logic             stop;
  logic             oneShot;
  logic             load;
  logic [WIDTH-1:0] divIn;
  logic             pulseOut;
  logic             busy;
  logic [WIDTH-1:0] count;

  modport master (
    output pulseIn, start, stop,
    output oneShot, load, divIn,
    input  pulseOut, busy, count
  );

  modport slave (
    input  pulseIn, start, stop,
    input  oneShot, load, divIn,
    output pulseOut, busy, count
  );
endinterface

// File: rtl/pulse_divider.sv
// Programmable pulse divider for the LED matrix timing chain.
// Emits a one-clock pulse every div qualifying cycles; cascadable.
module pulse_divider #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 10
) (
  input  logic            clk,
  input  logic            rst,
  pulse_divider_if.slave  bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             mode_q, mode_d;
  logic             pulse_q, pulse_d;
  logic             term;

  assign term = (count_q == div_q - ONE);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    div_d   = div_q;
    mode_d  = mode_q;
    pulse_d = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
    end else if (bus.load || bus.start) begin
      count_d = '0;
      if (bus.load)
        div_d = (bus.divIn == '0) ? ONE : bus.divIn;
      if (bus.start) begin
        state_d = RUN;
        mode_d  = bus.oneShot;
      end
    end else if (state_q == RUN && bus.pulseIn) begin
      if (term) begin
        count_d = '0;
        pulse_d = 1'b1;
        if (mode_q)
          state_d = IDLE;
      end else begin
        count_d = count_q + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      div_q   <= DEF;
      mode_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.pulseOut = pulse_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.count    = count_q;
endmodule
